sram_phy_ctrl: RTL

//  Consumes the SRAM request bundle after it has been re-registered into the SRAM clock domain.

---
 rtl/sram_phy_ctrl_if.sv | 33 +++
 rtl/sram_phy_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_phy_ctrl_if.sv
// Request/response bundle between the SRAM-domain request register stage
// and sram_phy_ctrl.
//   req_base_read_ce / req_base_write_ce : base bank read / write request
//   req_ext_read_ce  / req_ext_write_ce  : ext bank read / write request
//   req_addr_wdata_ce[103:0] : [103:84] base addr, [83:64] ext addr,
//                              [63:32] base wdata, [31:0] ext wdata
//   req_ready      : request accepted on this edge if any *_ce is high
//   rsp_valid      : one-cycle pulse, transaction finished
//   rsp_base_rdata : base read data, held until the next base read
//   rsp_ext_rdata  : ext read data, held until the next ext read
interface sram_phy_ctrl_if;
    logic         req_base_read_ce;
    logic         req_base_write_ce;
    logic         req_ext_read_ce;
    logic         req_ext_write_ce;
    logic [103:0] req_addr_wdata_ce;
    logic         req_ready;
    logic         rsp_valid;
    logic [31:0]  rsp_base_rdata;
    logic [31:0]  rsp_ext_rdata;

    modport master (
        output req_base_read_ce, req_base_write_ce,
        output req_ext_read_ce, req_ext_write_ce, req_addr_wdata_ce,
        input  req_ready, rsp_valid, rsp_base_rdata, rsp_ext_rdata
    );

    modport slave (
        input  req_base_read_ce, req_base_write_ce,
        input  req_ext_read_ce, req_ext_write_ce, req_addr_wdata_ce,
        output req_ready, rsp_valid, rsp_base_rdata, rsp_ext_rdata
    );
endinterface

// File: rtl/sram_phy_ctrl.sv
// Drives the base and ext asynchronous SRAM chips from the SRAM-domain
// request bundle. Both banks are serviced in parallel inside one transaction
// (IDLE -> ACCESS for N cycles -> DONE -> IDLE). Every SRAM pin comes
// straight from a flop; nothing on the request side reaches a pin
// combinationally.
// Ports:
//   clk, rst              : SRAM-domain clock, asynchronous active-high reset
//   host                  : request/response bundle (slave side)
//   {base,ext}_ram_data   : 32-bit bidirectional SRAM data bus
//   {base,ext}_ram_addr   : 20-bit SRAM address (0 when the bank is idle)
//   {base,ext}_ram_be_n   : byte enables, active-low
//   {base,ext}_ram_ce_n/oe_n/we_n : chip / output / write enables, active-low
module sram_phy_ctrl #(
    parameter int RD_WAIT  = 2,
    parameter int WR_SETUP = 1,
    parameter int WR_PULSE = 2,
    parameter int WR_HOLD  = 1
) (
    input  logic        clk,
    input  logic        rst,
    sram_phy_ctrl_if.slave host,
    inout  wire  [31:0] base_ram_data,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,
    inout  wire  [31:0] ext_ram_data,
    output logic [19:0] ext_ram_addr,
    output logic [3:0]  ext_ram_be_n,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n
);
    localparam int WR_N  = WR_SETUP + WR_PULSE + WR_HOLD;
    localparam int MAX_N = (WR_N > RD_WAIT) ? WR_N : RD_WAIT;
    localparam int CNT_W = $clog2(MAX_N) + 1;

    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_N - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WE_ON   = CNT_W'(WR_SETUP);
    localparam logic [CNT_W-1:0] WE_OFF  = CNT_W'(WR_SETUP + WR_PULSE);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_WR   = 2'd2;

    // A bank asking for both read and write performs only the write.
    function automatic logic [1:0] decode_op(input logic rd, input logic wr);
        if (wr)
            return OP_WR;
        if (rd)
            return OP_RD;
        return OP_NONE;
    endfunction

    // Control pins of one bank for a given ACCESS position: {ce_n, oe_n, we_n, drive}.
    // A read bank keeps oe_n low for the whole transaction, even when the
    // other bank stretches it to write length.
    function automatic logic [3:0] bank_ctl(input logic acc, input logic [1:0] op,
                                            input logic [CNT_W-1:0] c);
        logic on;
        logic rd;
        logic wr;
        on = acc && (op != OP_NONE);
        rd = acc && (op == OP_RD);
        wr = acc && (op == OP_WR);
        return {!on, !rd, !(wr && (c >= WE_ON) && (c < WE_OFF)), wr};
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic [1:0]       base_op;
    logic [1:0]       ext_op;
    logic [19:0]      base_addr_q;
    logic [19:0]      ext_addr_q;
    logic [31:0]      base_wdata_q;
    logic [31:0]      ext_wdata_q;
    logic             base_drv;
    logic             ext_drv;

    logic             accept;
    logic [1:0]       base_op_req;
    logic [1:0]       ext_op_req;

    assign base_op_req = decode_op(host.req_base_read_ce, host.req_base_write_ce);
    assign ext_op_req  = decode_op(host.req_ext_read_ce, host.req_ext_write_ce);
    assign accept      = (state == S_IDLE) &&
                         ((base_op_req != OP_NONE) || (ext_op_req != OP_NONE));

    assign host.req_ready = (state == S_IDLE);
    assign host.rsp_valid = (state == S_DONE);

    assign base_ram_data = base_drv ? base_wdata_q : 32'hzzzz_zzzz;
    assign ext_ram_data  = ext_drv  ? ext_wdata_q  : 32'hzzzz_zzzz;

    // View of the cycle that follows the coming edge; the pin flops are
    // loaded from it so the pins change exactly at the state transition.
    logic             acc_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic [1:0]       base_op_nx;
    logic [1:0]       ext_op_nx;
    logic [19:0]      base_addr_nx;
    logic [19:0]      ext_addr_nx;

    always_comb begin
        acc_nx       = 1'b0;
        cnt_nx       = cnt;
        base_op_nx   = base_op;
        ext_op_nx    = ext_op;
        base_addr_nx = base_addr_q;
        ext_addr_nx  = ext_addr_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    acc_nx       = 1'b1;
                    cnt_nx       = '0;
                    base_op_nx   = base_op_req;
                    ext_op_nx    = ext_op_req;
                    base_addr_nx = host.req_addr_wdata_ce[103:84];
                    ext_addr_nx  = host.req_addr_wdata_ce[83:64];
                end
            end
            S_ACCESS: begin
                if (cnt != last) begin
                    acc_nx = 1'b1;
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Transaction sequencing and read-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= S_IDLE;
            cnt                 <= '0;
            last                <= '0;
            base_op             <= OP_NONE;
            ext_op              <= OP_NONE;
            host.rsp_base_rdata <= '0;
            host.rsp_ext_rdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state   <= S_ACCESS;
                        cnt     <= '0;
                        base_op <= base_op_req;
                        ext_op  <= ext_op_req;
                        last    <= ((base_op_req == OP_WR) || (ext_op_req == OP_WR)) ?
                                   WR_LAST : RD_LAST;
                    end
                end
                S_ACCESS: begin
                    if (cnt == last) begin
                        state <= S_DONE;
                        if (base_op == OP_RD)
                            host.rsp_base_rdata <= base_ram_data;
                        if (ext_op == OP_RD)
                            host.rsp_ext_rdata <= ext_ram_data;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request address/data holding registers
    always_ff @(posedge clk) begin
        if (accept) begin
            base_addr_q  <= host.req_addr_wdata_ce[103:84];
            ext_addr_q   <= host.req_addr_wdata_ce[83:64];
            base_wdata_q <= host.req_addr_wdata_ce[63:32];
            ext_wdata_q  <= host.req_addr_wdata_ce[31:0];
        end
    end

    // SRAM pin registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {base_ram_ce_n, base_ram_oe_n, base_ram_we_n, base_drv} <= 4'b1110;
            {ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, ext_drv}     <= 4'b1110;
            base_ram_be_n <= 4'hF;
            ext_ram_be_n  <= 4'hF;
            base_ram_addr <= '0;
            ext_ram_addr  <= '0;
        end else begin
            {base_ram_ce_n, base_ram_oe_n, base_ram_we_n, base_drv} <=
                bank_ctl(acc_nx, base_op_nx, cnt_nx);
            {ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, ext_drv} <=
                bank_ctl(acc_nx, ext_op_nx, cnt_nx);
            base_ram_be_n <= (acc_nx && (base_op_nx != OP_NONE)) ? 4'h0 : 4'hF;
            ext_ram_be_n  <= (acc_nx && (ext_op_nx != OP_NONE)) ? 4'h0 : 4'hF;
            base_ram_addr <= (acc_nx && (base_op_nx != OP_NONE)) ? base_addr_nx : 20'h0;
            ext_ram_addr  <= (acc_nx && (ext_op_nx != OP_NONE)) ? ext_addr_nx : 20'h0;
        end
    end
endmodule
